// File: rtl/m68k_bus_ctrl_pkg.sv
// Shared types and constants for the 68000 bus controller: region codes,
// address-nibble decode values, FSM state encoding and select bit positions.
package m68k_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        REGION_ROM,
        REGION_WRAM,
        REGION_PORT,
        REGION_IO,
        REGION_SROM,
        REGION_SRAM,
        REGION_UNMAPPED
    } region_e;

    localparam logic [3:0] DEC_ROM  = 4'h0;
    localparam logic [3:0] DEC_WRAM = 4'h1;
    localparam logic [3:0] DEC_PORT = 4'h2;
    localparam logic [3:0] DEC_IO   = 4'h3;
    localparam logic [3:0] DEC_SROM = 4'hC;
    localparam logic [3:0] DEC_SRAM = 4'hD;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_ACK  = 2'd2;

    localparam int SEL_ROMOE   = 0;
    localparam int SEL_WRAM_CS = 1;
    localparam int SEL_PORTOE  = 2;
    localparam int SEL_PORTWE  = 3;
    localparam int SEL_IO_CS   = 4;
    localparam int SEL_SROMOE  = 5;
    localparam int SEL_SRAM_CS = 6;
    localparam int SEL_W       = 7;

    // Active-high mask of the select that a latched access drives.
    // ROM/SROM writes and unmapped accesses select nothing.
    function automatic logic [SEL_W-1:0] sel_mask(input region_e region,
                                                  input logic    rd,
                                                  input logic    strobe);
        logic [SEL_W-1:0] m;
        m = '0;
        case (region)
            REGION_ROM:  m[SEL_ROMOE]   = rd;
            REGION_WRAM: m[SEL_WRAM_CS] = 1'b1;
            REGION_PORT: begin
                m[SEL_PORTOE] = rd;
                m[SEL_PORTWE] = !rd && strobe;
            end
            REGION_IO:   m[SEL_IO_CS]   = 1'b1;
            REGION_SROM: m[SEL_SROMOE]  = rd;
            REGION_SRAM: m[SEL_SRAM_CS] = 1'b1;
            default:     m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/m68k_addr_decode.sv
// Combinational region decode of ADDR[23:20] with per-region wait-state count.
module m68k_addr_decode
    import m68k_bus_ctrl_pkg::*;
#(
    parameter int unsigned WS_PORT = 1,
    parameter int unsigned WS_IO   = 1,
    parameter int unsigned WS_SRAM = 1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic [3:0] addr_hi,
    output region_e    region,
    output logic [3:0] ws
);

    always_comb begin
        region = REGION_UNMAPPED;
        ws     = 4'(TIMEOUT);
        case (addr_hi)
            DEC_ROM:  begin region = REGION_ROM;  ws = 4'd0;        end
            DEC_WRAM: begin region = REGION_WRAM; ws = 4'd0;        end
            DEC_PORT: begin region = REGION_PORT; ws = 4'(WS_PORT); end
            DEC_IO:   begin region = REGION_IO;   ws = 4'(WS_IO);   end
            DEC_SROM: begin region = REGION_SROM; ws = 4'd0;        end
            DEC_SRAM: begin region = REGION_SRAM; ws = 4'(WS_SRAM); end
            default:  begin region = REGION_UNMAPPED; ws = 4'(TIMEOUT); end
        endcase
    end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus cycle controller: latches region on nAS, inserts wait states,
// drives registered chip selects and nDTACK, force-acks unmapped accesses.
module m68k_bus_ctrl
    import m68k_bus_ctrl_pkg::*;
#(
    parameter int unsigned WS_PORT = 1,
    parameter int unsigned WS_IO   = 1,
    parameter int unsigned WS_SRAM = 1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK_68KCLK,
    input  logic        nRESET,
    input  logic [23:1] M68K_ADDR,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        M68K_RW,
    output logic        nDTACK,
    output logic        nROMOE,
    output logic        nWRAM_CS,
    output logic        nPORTOE,
    output logic        nPORTWE,
    output logic        nIO_CS,
    output logic        nSROMOE,
    output logic        nSRAM_CS,
    output logic        BUS_TIMEOUT
);

    region_e          dec_region;
    logic [3:0]       dec_ws;

    state_t           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    region_e          region_q, region_d;
    logic             rw_q, rw_d;
    logic [SEL_W-1:0] sel_n_q, sel_n_d;
    logic             dtack_n_q, dtack_n_d;
    logic             timeout_q, timeout_d;
    logic             unused_addr;

    assign unused_addr = ^M68K_ADDR[19:1];

    m68k_addr_decode #(
        .WS_PORT (WS_PORT),
        .WS_IO   (WS_IO),
        .WS_SRAM (WS_SRAM),
        .TIMEOUT (TIMEOUT)
    ) u_decode (
        .addr_hi (M68K_ADDR[23:20]),
        .region  (dec_region),
        .ws      (dec_ws)
    );

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        region_d  = region_q;
        rw_d      = rw_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!nAS) begin
                    region_d = dec_region;
                    rw_d     = M68K_RW;
                    wcnt_d   = dec_ws;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (nAS) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == 4'd0) begin
                    state_d   = ST_ACK;
                    timeout_d = (region_q == REGION_UNMAPPED);
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                if (nAS) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they track it with no lag.
        sel_n_d   = '1;
        if (state_d != ST_IDLE) begin
            sel_n_d = ~sel_mask(region_d, rw_d, !nUDS || !nLDS);
        end
        dtack_n_d = (state_d != ST_ACK);
    end

    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= 4'd0;
            region_q  <= REGION_UNMAPPED;
            rw_q      <= 1'b1;
            sel_n_q   <= '1;
            dtack_n_q <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            region_q  <= region_d;
            rw_q      <= rw_d;
            sel_n_q   <= sel_n_d;
            dtack_n_q <= dtack_n_d;
            timeout_q <= timeout_d;
        end
    end

    assign nDTACK      = dtack_n_q;
    assign nROMOE      = sel_n_q[SEL_ROMOE];
    assign nWRAM_CS    = sel_n_q[SEL_WRAM_CS];
    assign nPORTOE     = sel_n_q[SEL_PORTOE];
    assign nPORTWE     = sel_n_q[SEL_PORTWE];
    assign nIO_CS      = sel_n_q[SEL_IO_CS];
    assign nSROMOE     = sel_n_q[SEL_SROMOE];
    assign nSRAM_CS    = sel_n_q[SEL_SRAM_CS];
    assign BUS_TIMEOUT = timeout_q;

endmodule

// File: doc/m68k_bus_ctrl.md
M68K_BUS_CTRL -- requirements
Module: m68k_bus_ctrl

Interface
REQ-001 Parameter WS_PORT, default 1, wait states for the 0x200000-0x2FFFFF region.
REQ-002 Parameter WS_IO, default 1, wait states for the 0x300000-0x3FFFFF region.
REQ-003 Parameter WS_SRAM, default 1, wait states for the 0xD00000-0xDFFFFF region.
REQ-004 Parameter TIMEOUT, default 15, wait cycles before a forced acknowledge of an unmapped access (range 1-15).
REQ-005 CLK_68KCLK  in  1  single clock; all state updates on its rising edge.
REQ-006 nRESET  in  1  reset, asynchronous, active-low.
REQ-007 M68K_ADDR  in  23  CPU address bits [23:1].
REQ-008 nAS, nUDS, nLDS  in  1 each  CPU address strobe and data strobes, active-low.
REQ-009 M68K_RW  in  1  1 = read, 0 = write.
REQ-010 nDTACK  out  1  data acknowledge to the CPU, active-low.
REQ-011 nROMOE, nWRAM_CS, nPORTOE, nPORTWE, nIO_CS, nSROMOE, nSRAM_CS  out  1 each  region selects, active-low.
REQ-012 BUS_TIMEOUT  out  1  one-cycle high pulse when an unmapped access is force-acknowledged.

Function
REQ-013 Decode on ADDR[23:20]: 0x0 ROM (ws 0), 0x1 WRAM (ws 0), 0x2 PORT (WS_PORT), 0x3 IO (WS_IO), 0xC SROM (ws 0), 0xD SRAM (WS_SRAM); all other values are UNMAPPED.
REQ-014 FSM states IDLE, WAIT, ACK; 4-bit down-counter WCNT.
REQ-015 IDLE: at an edge sampling nAS=0, latch region and RW, load WCNT with the region's wait-state count (TIMEOUT if UNMAPPED), go to WAIT.
REQ-016 WAIT: if nAS=1, go to IDLE (abort); else if WCNT=0, go to ACK; else decrement WCNT.
REQ-017 ACK: nDTACK low; hold until an edge samples nAS=1, then go to IDLE with nDTACK high in the same cycle.
REQ-018 Latency: nAS sampled low at edge N -> selected CS low after edge N; nDTACK low after edge N+1+ws.
REQ-019 Selects are registered, asserted in WAIT and ACK only, and only for the latched region; at most one select is low at any time.
REQ-020 ROM, SROM and PORT: read gives nROMOE/nSROMOE/nPORTOE; writes to ROM and SROM assert no select but are still acknowledged with ws 0.
REQ-021 PORT write: nPORTWE low only while (nUDS=0 or nLDS=0) in WAIT/ACK; nPORTOE stays high.
REQ-022 WRAM, IO and SRAM selects assert for both read and write.
REQ-023 UNMAPPED: no select asserts; on the WAIT->ACK transition BUS_TIMEOUT is high for exactly one cycle.
REQ-024 Address and RW are ignored after latching; changes mid-cycle have no effect.
REQ-025 Back-to-back accesses: IDLE needs one edge sampling nAS=1 between cycles, so no new cycle starts from ACK without passing through IDLE.
REQ-026 Abort (nAS high before ACK): selects and nDTACK go high at the next edge, and BUS_TIMEOUT does not pulse.

Reset
REQ-027 While nRESET=0: state IDLE, WCNT=0, all selects high, nDTACK high, BUS_TIMEOUT low, asynchronously.
REQ-028 Reset asserted mid-cycle forces the reset values immediately; after release, a still-low nAS starts a fresh cycle from IDLE.

Structure
REQ-029 A shared package holds the region enum (ROM, WRAM, PORT, IO, SROM, SRAM, UNMAPPED), the ADDR[23:20] decode constants and the FSM state type.
REQ-030 One sub-module, m68k_addr_decode, is combinational: ADDR[23:20] in, region and wait-state count out.

Verification
REQ-031 Read 0x000100, ws 0, nAS low at edge 0 -> nROMOE low after edge 0, nDTACK low after edge 1; both high one edge after nAS rises.
REQ-032 Write 0x200000 with WS_PORT=3, nUDS low -> nPORTWE low, nPORTOE high, nDTACK low after edge 4.
REQ-033 Read 0x800000 -> no select asserts, BUS_TIMEOUT pulses once and nDTACK goes low after edge 16.
REQ-034 Read 0xD00010, WS_SRAM=1, nAS released after edge 1 -> nSRAM_CS high after edge 2, nDTACK never low.
REQ-035 nRESET pulsed low during the WAIT of an IO access -> all outputs return to reset values immediately; after release with nAS still low, nIO_CS is low one edge later.
REQ-036 Back-to-back reads of 0x100000 then 0xC00000 separated by one nAS-high cycle -> nWRAM_CS then nSROMOE, never both low, each acknowledged with ws 0.
